// File: rtl/mem_arbiter_if.sv
// Request/grant bus between the two memory requesters and mem_arbiter.
// The requester side drives the master modport; the arbiter takes the slave modport.
interface mem_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
  );
endinterface

// File: rtl/mem_arbiter.sv
// Zero-fills the data memory after reset, then shares its single port
// between two requesters with round-robin arbitration.
module mem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              Clock,
  input  logic              R,
  mem_arbiter_if.slave      bus,
  output logic              init_done,
  output logic              mem_WriteEn,
  output logic [ADDR_W-1:0] mem_Addy,
  output logic [DATA_W-1:0] mem_WriteData,
  input  logic [DATA_W-1:0] mem_ReadData
);

  typedef enum logic [1:0] {
    START = 2'd0,
    INIT  = 2'd1,
    ARB   = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

  state_t          state;
  logic [ADDR_W:0] init_cnt;
  logic            last;

  // Grant decision: a lone requester wins; on contention the port not served last wins.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    bus.gnt0 = 1'b0;
    bus.gnt1 = 1'b0;
    if (state == ARB) begin
      if (bus.req0 && (!bus.req1 || last)) bus.gnt0 = 1'b1;
      else if (bus.req1)                   bus.gnt1 = 1'b1;
    end
  end

  // Memory port mux: init sequencer during INIT, otherwise the granted requester.
  always_comb begin
    mem_WriteEn   = 1'b0;
    mem_Addy      = '0;
    mem_WriteData = '0;
    if (state == INIT) begin
      mem_WriteEn   = 1'b1;
      mem_Addy      = init_cnt[ADDR_W-1:0];
      mem_WriteData = '0;
    end else if (bus.gnt0) begin
      mem_WriteEn   = bus.we0;
      mem_Addy      = bus.addr0;
      mem_WriteData = bus.wdata0;
    end else if (bus.gnt1) begin
      mem_WriteEn   = bus.we1;
      mem_Addy      = bus.addr1;
      mem_WriteData = bus.wdata1;
    end
  end

  // Sequencer FSM: one idle cycle, DEPTH zero-fill writes, then arbitration forever.
  always_ff @(posedge Clock or negedge R) begin
    if (!R) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state     <= START;
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        START: state <= INIT;
        INIT: begin
          init_cnt <= init_cnt + (ADDR_W+1)'(1);
          if (init_cnt == LAST_IDX) begin
            state     <= ARB;
            init_done <= 1'b1;
          end
        end
        ARB:     state <= ARB;
        default: state <= START;
      endcase
    end
  end

  // Accepted transactions: remember the winner and capture read data for one-cycle rvalid.
  always_ff @(posedge Clock or negedge R) begin
    if (!R) begin
      last        <= 1'b1;
      bus.rvalid0 <= 1'b0;
      bus.rvalid1 <= 1'b0;
      bus.rdata0  <= '0;
      bus.rdata1  <= '0;
    end else begin
      bus.rvalid0 <= bus.gnt0 && !bus.we0;
      bus.rvalid1 <= bus.gnt1 && !bus.we1;
      if (bus.gnt0) last <= 1'b0;
      if (bus.gnt1) last <= 1'b1;
      if (bus.gnt0 && !bus.we0) bus.rdata0 <= mem_ReadData;
      if (bus.gnt1 && !bus.we1) bus.rdata1 <= mem_ReadData;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural data memory, scoreboard
// of expected read data, and one task per scenario.
module tb_mem_arbiter;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  logic              init_done;
  logic              mem_WriteEn;
  logic [ADDR_W-1:0] mem_Addy;
  logic [DATA_W-1:0] mem_WriteData;
  logic [DATA_W-1:0] mem_ReadData;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .Clock         (clk),
    .R             (rst_n),
    .bus           (bus),
    .init_done     (init_done),
    .mem_WriteEn   (mem_WriteEn),
    .mem_Addy      (mem_Addy),
    .mem_WriteData (mem_WriteData),
    .mem_ReadData  (mem_ReadData)
  );

  // Behavioural data memory: synchronous write, combinational read.
  logic [DATA_W-1:0] env_mem [DEPTH];
  logic              junk_fill = 1'b0;

  always @(posedge clk) begin
    if (junk_fill) begin
      for (int i = 0; i < DEPTH; i++) env_mem[i] <= 32'hdead_0000 | 32'(i);
    end else if (mem_WriteEn) begin
      env_mem[mem_Addy] <= mem_WriteData;
    end
  end

  assign mem_ReadData = env_mem[mem_Addy];

  int tests  = 0;
  int errors = 0;

  // Scoreboard state.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] q0 [$];
  logic [DATA_W-1:0] q1 [$];
  bit                exp0 = 1'b0;
  bit                exp1 = 1'b0;
  int                rv1_count = 0;

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
  endtask

  // Scoreboard: push expected read data on each read grant, pop on the following rvalid.
  task automatic monitor();
    logic [DATA_W-1:0] d;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q0.delete(); q1.delete();
        exp0 = 1'b0; exp1 = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      end else begin
        if (exp0 || bus.rvalid0) begin
          tests++;
          d = '0;
          if (q0.size() > 0) d = q0.pop_front();
          if (bus.rvalid0 !== exp0 || bus.rdata0 !== d) begin
            errors++;
            $display("FAIL sb_port0: rvalid0=%b rdata0=%h, expected rvalid0=%b rdata0=%h",
                     bus.rvalid0, bus.rdata0, exp0, d);
          end
        end
        if (exp1 || bus.rvalid1) begin
          tests++;
          d = '0;
          if (q1.size() > 0) d = q1.pop_front();
          if (bus.rvalid1 === 1'b1) rv1_count++;
          if (bus.rvalid1 !== exp1 || bus.rdata1 !== d) begin
            errors++;
            $display("FAIL sb_port1: rvalid1=%b rdata1=%h, expected rvalid1=%b rdata1=%h",
                     bus.rvalid1, bus.rdata1, exp1, d);
          end
        end
        exp0 = 1'b0;
        exp1 = 1'b0;
        if (bus.gnt0 === 1'b1 && bus.gnt1 === 1'b1) begin
          tests++;
          errors++;
          $display("FAIL one_grant: gnt0=1 gnt1=1, expected at most one grant");
        end
        if (bus.gnt0 === 1'b1) begin
          if (bus.we0) ref_mem[bus.addr0] = bus.wdata0;
          else begin q0.push_back(ref_mem[bus.addr0]); exp0 = 1'b1; end
        end
        if (bus.gnt1 === 1'b1) begin
          if (bus.we1) ref_mem[bus.addr1] = bus.wdata1;
          else begin q1.push_back(ref_mem[bus.addr1]); exp1 = 1'b1; end
        end
      end
    end
  endtask

  // Called at posedge+1 right after reset release; walks START, INIT and the first ARB cycle.
  task automatic check_init(input bit hold_req1);
    bit                e_we, e_done, e_g1;
    logic [ADDR_W-1:0] e_addr;
    for (int c = 0; c <= DEPTH + 1; c++) begin
      @(negedge clk);
      e_we   = (c >= 1 && c <= DEPTH);
      e_addr = e_we ? ADDR_W'(c - 1) : '0;
      e_done = (c == DEPTH + 1);
      e_g1   = hold_req1 && (c == DEPTH + 1);
      tests++;
      if (mem_WriteEn !== e_we || mem_Addy !== e_addr || mem_WriteData !== '0 ||
          init_done !== e_done || bus.gnt0 !== 1'b0 || bus.gnt1 !== e_g1) begin
        errors++;
        $display("FAIL init_c%0d: we=%b addr=%0d data=%h done=%b gnt=%b%b, expected we=%b addr=%0d data=0 done=%b gnt=0%b",
                 c, mem_WriteEn, mem_Addy, mem_WriteData, init_done, bus.gnt0, bus.gnt1,
                 e_we, e_addr, e_done, e_g1);
      end
      @(posedge clk); #1;
    end
  endtask

  // One transaction on a port; waits (bounded) for the grant. Returns cycles spent.
  task automatic xact(input int port, input bit we, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] data, input bit hold, output int waited);
    bit granted;
    if (port == 0) begin bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = data; end
    else           begin bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = data; end
    granted = 1'b0;
    waited  = 0;
    for (int i = 0; i < 8 && !granted; i++) begin
      @(negedge clk);
      granted = (port == 0) ? (bus.gnt0 === 1'b1) : (bus.gnt1 === 1'b1);
      waited++;
      @(posedge clk); #1;
    end
    tests++;
    if (!granted) begin
      errors++;
      $display("FAIL xact_timeout: port %0d addr %0d got no grant, expected one within 8 cycles", port, addr);
    end
    if (!hold) begin
      if (port == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 rst_n = 1'b0;
    junk_fill = 1'b1;
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.we0 = 1'b1; bus.wdata0 = 32'h1234_5678;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tests++;
      if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0 || bus.rvalid0 !== 1'b0 || bus.rvalid1 !== 1'b0 ||
          bus.rdata0 !== '0 || bus.rdata1 !== '0 || init_done !== 1'b0 ||
          mem_WriteEn !== 1'b0 || mem_Addy !== '0 || mem_WriteData !== '0) begin
        errors++;
        $display("FAIL reset_outputs: gnt=%b%b rvalid=%b%b rdata0=%h rdata1=%h done=%b we=%b addr=%0d wd=%h, expected all 0",
                 bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.rdata0, bus.rdata1,
                 init_done, mem_WriteEn, mem_Addy, mem_WriteData);
      end
      @(posedge clk); #1;
    end
    junk_fill = 1'b0;
    idle_inputs();
    // Port 1 asks for a read of addr 0 throughout init; it must wait until ARB.
    bus.req1 = 1'b1;
    rst_n = 1'b1;
    check_init(1'b1);
    bus.req1 = 1'b0;
  endtask

  task automatic test_single_port();
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 5'd1; bus.wdata0 = 32'd7;
    @(negedge clk);
    tests++;
    if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0 || mem_WriteEn !== 1'b1 ||
        mem_Addy !== 5'd1 || mem_WriteData !== 32'd7) begin
      errors++;
      $display("FAIL single_write: gnt=%b%b we=%b addr=%0d wd=%h, expected gnt=10 we=1 addr=1 wd=7",
               bus.gnt0, bus.gnt1, mem_WriteEn, mem_Addy, mem_WriteData);
    end
    @(posedge clk); #1;
    bus.we0 = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.gnt0 !== 1'b1 || mem_WriteEn !== 1'b0 || mem_Addy !== 5'd1) begin
      errors++;
      $display("FAIL single_read_gnt: gnt0=%b we=%b addr=%0d, expected gnt0=1 we=0 addr=1",
               bus.gnt0, mem_WriteEn, mem_Addy);
    end
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 32'd7 || bus.rvalid1 !== 1'b0) begin
      errors++;
      $display("FAIL single_rdata: rvalid0=%b rdata0=%h rvalid1=%b, expected rvalid0=1 rdata0=7 rvalid1=0",
               bus.rvalid0, bus.rdata0, bus.rvalid1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (bus.rvalid0 !== 1'b0 || bus.rdata0 !== 32'd7) begin
      errors++;
      $display("FAIL single_hold: rvalid0=%b rdata0=%h, expected rvalid0=0 rdata0=7",
               bus.rvalid0, bus.rdata0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int waited;
    int slow;
    int rv_start;
    slow = 0;
    rv_start = rv1_count;
    for (int a = 0; a < DEPTH; a++) begin
      xact(1, 1'b0, ADDR_W'(a), '0, (a != DEPTH - 1), waited);
      if (waited != 1) slow++;
    end
    @(negedge clk);
    @(posedge clk); #1;
    tests++;
    if (slow != 0 || rv1_count - rv_start != DEPTH) begin
      errors++;
      $display("FAIL b2b_reads: stalled=%0d rvalid1_pulses=%0d, expected stalled=0 pulses=%0d",
               slow, rv1_count - rv_start, DEPTH);
    end
  endtask

  task automatic test_contention();
    bit e0;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 5'd1; bus.wdata0 = 32'h7fff_ffff;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 5'd1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      e0 = (k % 2 == 0);
      tests++;
      if (bus.gnt0 !== e0 || bus.gnt1 !== !e0) begin
        errors++;
        $display("FAIL contention_gnt%0d: gnt=%b%b, expected gnt=%b%b", k, bus.gnt0, bus.gnt1, e0, !e0);
      end
      if (k == 2 || k == 4) begin
        tests++;
        if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== 32'h7fff_ffff) begin
          errors++;
          $display("FAIL contention_rdata%0d: rvalid1=%b rdata1=%h, expected 1 7fffffff",
                   k, bus.rvalid1, bus.rdata1);
        end
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    @(negedge clk);
    tests++;
    if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== 32'h7fff_ffff) begin
      errors++;
      $display("FAIL contention_rdata6: rvalid1=%b rdata1=%h, expected 1 7fffffff", bus.rvalid1, bus.rdata1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_boundary();
    int waited;
    xact(1, 1'b1, 5'd31, 32'h8000_0000, 1'b0, waited);
    xact(0, 1'b0, 5'd31, '0, 1'b0, waited);
    @(negedge clk);
    tests++;
    if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 32'h8000_0000) begin
      errors++;
      $display("FAIL boundary_read: rvalid0=%b rdata0=%h, expected 1 80000000", bus.rvalid0, bus.rdata0);
    end
    tests++;
    if (env_mem[0] !== 32'h0 || env_mem[31] !== 32'h8000_0000) begin
      errors++;
      $display("FAIL boundary_wrap: mem[0]=%h mem[31]=%h, expected 0 80000000", env_mem[0], env_mem[31]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int waited;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 5'd31;
    @(negedge clk);
    tests++;
    if (bus.gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre: gnt0=%b, expected 1", bus.gnt0);
    end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (bus.gnt0 !== 1'b0 || mem_Addy !== '0 || mem_WriteEn !== 1'b0) begin
      errors++;
      $display("FAIL midreset_gnt: gnt0=%b addr=%0d we=%b, expected 0 0 0", bus.gnt0, mem_Addy, mem_WriteEn);
    end
    @(negedge clk);
    tests++;
    if (bus.rvalid0 !== 1'b0 || bus.rdata0 !== '0) begin
      errors++;
      $display("FAIL midreset_rvalid: rvalid0=%b rdata0=%h, expected 0 0", bus.rvalid0, bus.rdata0);
    end
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_init(1'b0);
    xact(0, 1'b0, 5'd31, '0, 1'b0, waited);
    @(negedge clk);
    tests++;
    if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 32'h0) begin
      errors++;
      $display("FAIL midreset_reinit: rvalid0=%b rdata0=%h, expected 1 0", bus.rvalid0, bus.rdata0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    idle_inputs();
    fork
      monitor();
    join_none
    test_reset();
    test_single_port();
    test_back_to_back();
    test_contention();
    test_boundary();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
